// File: rtl/operand_seq_ctrl.sv
// operand_seq_ctrl: multi-cycle control sequencer for the 8-bit datapath.
// Fetches a 15-bit instruction word, decodes its src/dst fields, drives the
// B-operand mux select, sequences data-memory read/write handshakes and
// raises register write enables, a PC increment pulse and a retire count.
//
// Optional build macro: OPERAND_SEQ_TIMEOUT_EN
//   defined   -> every handshake wait is bounded by TIMEOUT cycles; an
//                expired wait parks the FSM in ERROR (err_o sticky) until reset.
//   undefined -> waits are unbounded and err_o is tied low.
//
// Handshake semantics: a request output (fetch_req_o, mem_req_o) is held high
// for the whole wait state; the matching completion input (instr_valid_i,
// mem_ack_i) is sampled only while that request is high and completes the
// transfer on the rising edge where both are high. Completion inputs seen
// outside their wait state are ignored.
module operand_seq_ctrl #(
  parameter int CNT_W   = 16,
  parameter int TIMEOUT = 255
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             run_i,
  output logic             fetch_req_o,
  input  logic             instr_valid_i,
  input  logic [14:0]      instr_i,
  output logic [1:0]       sel_b_o,
  output logic [2:0]       alu_op_o,
  output logic             reg_a_we_o,
  output logic             reg_b_we_o,
  output logic             mem_req_o,
  output logic             mem_we_o,
  output logic [7:0]       mem_addr_o,
  input  logic             mem_ack_i,
  output logic             pc_inc_o,
  output logic             busy_o,
  output logic [CNT_W-1:0] retire_cnt_o,
  output logic             err_o,
  output logic [2:0]       state_dbg_o
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_FETCH  = 3'd1;
  localparam logic [2:0] S_DECODE = 3'd2;
  localparam logic [2:0] S_MEM_RD = 3'd3;
  localparam logic [2:0] S_EXEC   = 3'd4;
  localparam logic [2:0] S_MEM_WR = 3'd5;
  localparam logic [2:0] S_ERROR  = 3'd6;

  localparam logic [1:0] SRC_MEM  = 2'b01;
  localparam logic [1:0] DST_REGA = 2'b01;
  localparam logic [1:0] DST_REGB = 2'b10;
  localparam logic [1:0] DST_MEM  = 2'b11;
  localparam logic [1:0] SEL_ZERO = 2'b11;

  logic [2:0]       state;
  logic [2:0]       state_nx;
  logic [14:0]      ir;
  logic [CNT_W-1:0] retire_cnt;
  logic             retire;

  logic [2:0] ir_op;
  logic [1:0] ir_dst;
  logic [1:0] ir_src;
  logic [7:0] ir_lit;

  assign ir_op  = ir[14:12];
  assign ir_dst = ir[11:10];
  assign ir_src = ir[9:8];
  assign ir_lit = ir[7:0];

`ifdef OPERAND_SEQ_TIMEOUT_EN
  localparam int WAIT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

  logic [WAIT_W-1:0] wait_cnt;
  logic              waiting;
  logic              handshake;

  // A wait state is one that parks on an external completion input.
  always_comb begin
    waiting   = (state == S_FETCH) || (state == S_MEM_RD) || (state == S_MEM_WR);
    handshake = (state == S_FETCH) ? instr_valid_i : mem_ack_i;
  end
`endif

  // Next-state and retirement decode; retire also serves as the PC pulse.
  always_comb begin
    state_nx = state;
    retire   = 1'b0;
    case (state)
      S_IDLE:   if (run_i) state_nx = S_FETCH;
      S_FETCH:  if (instr_valid_i) state_nx = S_DECODE;
      S_DECODE: state_nx = (ir_src == SRC_MEM) ? S_MEM_RD : S_EXEC;
      S_MEM_RD: if (mem_ack_i) state_nx = S_EXEC;
      S_EXEC: begin
        if (ir_dst == DST_MEM) begin
          state_nx = S_MEM_WR;
        end else begin
          retire   = 1'b1;
          state_nx = run_i ? S_FETCH : S_IDLE;
        end
      end
      S_MEM_WR: begin
        if (mem_ack_i) begin
          retire   = 1'b1;
          state_nx = run_i ? S_FETCH : S_IDLE;
        end
      end
      S_ERROR:  state_nx = S_ERROR;
      default:  state_nx = S_IDLE;
    endcase
`ifdef OPERAND_SEQ_TIMEOUT_EN
    // A completion arriving on the last allowed cycle still wins.
    if (waiting && !handshake && (wait_cnt == WAIT_W'(TIMEOUT - 1))) begin
      state_nx = S_ERROR;
      retire   = 1'b0;
    end
`endif
  end

  // State, instruction register and retire counter.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state      <= S_IDLE;
      ir         <= '0;
      retire_cnt <= '0;
    end else begin
      state <= state_nx;
      if ((state == S_FETCH) && instr_valid_i) ir <= instr_i;
      if (retire) retire_cnt <= retire_cnt + 1'b1;
    end
  end

`ifdef OPERAND_SEQ_TIMEOUT_EN
  // Wait counter restarts on every state change and counts waiting cycles.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wait_cnt <= '0;
    end else if (state_nx != state) begin
      wait_cnt <= '0;
    end else if (waiting) begin
      wait_cnt <= wait_cnt + 1'b1;
    end
  end

  assign err_o = (state == S_ERROR);
`else
  // Without the watchdog TIMEOUT has no effect; the comparison is constant 0.
  assign err_o = (TIMEOUT < 0);
`endif

  // Moore output decode from state and IR; only the MEM_WR retire pulse
  // follows the acknowledge of that same cycle.
  always_comb begin
    fetch_req_o = 1'b0;
    sel_b_o     = SEL_ZERO;
    alu_op_o    = 3'b000;
    reg_a_we_o  = 1'b0;
    reg_b_we_o  = 1'b0;
    mem_req_o   = 1'b0;
    mem_we_o    = 1'b0;
    mem_addr_o  = 8'h00;
    case (state)
      S_FETCH: fetch_req_o = 1'b1;
      S_MEM_RD: begin
        mem_req_o  = 1'b1;
        mem_addr_o = ir_lit;
        sel_b_o    = SRC_MEM;
      end
      S_EXEC: begin
        sel_b_o    = ir_src;
        alu_op_o   = ir_op;
        reg_a_we_o = (ir_dst == DST_REGA);
        reg_b_we_o = (ir_dst == DST_REGB);
      end
      S_MEM_WR: begin
        mem_req_o  = 1'b1;
        mem_we_o   = 1'b1;
        mem_addr_o = ir_lit;
        sel_b_o    = ir_src;
        alu_op_o   = ir_op;
      end
      default: ;
    endcase
  end

  assign pc_inc_o     = retire;
  assign busy_o       = (state != S_IDLE);
  assign retire_cnt_o = retire_cnt;
  assign state_dbg_o  = state;

endmodule

// File: tb/tb_operand_seq_ctrl.sv
// Self-checking bench for operand_seq_ctrl. Each issued instruction pushes
// its expected retirement record to exp_q; the monitor pops and compares on
// every pc_inc_o pulse. Directed checks cover reset, latency, memory phases,
// run_i drop, asynchronous reset and (when OPERAND_SEQ_TIMEOUT_EN is defined)
// the handshake timeout.
module tb_operand_seq_ctrl;

  localparam int CNT_W = 4;
  localparam int W     = 21;

  logic             clk_i;
  logic             rst_ni;
  logic             run_i;
  logic             fetch_req_o;
  logic             instr_valid_i;
  logic [14:0]      instr_i;
  logic [1:0]       sel_b_o;
  logic [2:0]       alu_op_o;
  logic             reg_a_we_o;
  logic             reg_b_we_o;
  logic             mem_req_o;
  logic             mem_we_o;
  logic [7:0]       mem_addr_o;
  logic             mem_ack_i;
  logic             pc_inc_o;
  logic             busy_o;
  logic [CNT_W-1:0] retire_cnt_o;
  logic             err_o;
  logic [2:0]       state_dbg_o;

  operand_seq_ctrl #(.CNT_W(CNT_W), .TIMEOUT(8)) dut (
    .clk_i         (clk_i),
    .rst_ni        (rst_ni),
    .run_i         (run_i),
    .fetch_req_o   (fetch_req_o),
    .instr_valid_i (instr_valid_i),
    .instr_i       (instr_i),
    .sel_b_o       (sel_b_o),
    .alu_op_o      (alu_op_o),
    .reg_a_we_o    (reg_a_we_o),
    .reg_b_we_o    (reg_b_we_o),
    .mem_req_o     (mem_req_o),
    .mem_we_o      (mem_we_o),
    .mem_addr_o    (mem_addr_o),
    .mem_ack_i     (mem_ack_i),
    .pc_inc_o      (pc_inc_o),
    .busy_o        (busy_o),
    .retire_cnt_o  (retire_cnt_o),
    .err_o         (err_o),
    .state_dbg_o   (state_dbg_o)
  );

  // Clock and watchdog
  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  initial begin
    #200000;
    $display("FAIL watchdog: run did not finish within time limit");
    $fatal(1);
  end

  // Scoreboard state
  int               n_cmp;
  int               n_err;
  logic [W-1:0]     exp_q[$];
  logic [CNT_W-1:0] exp_cnt;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Expected outputs on the retire cycle of an instruction.
  function automatic logic [W-1:0] model(input logic [14:0] ins, input logic [CNT_W-1:0] cnt);
    logic [2:0] op;
    logic [1:0] dst;
    logic [1:0] src;
    logic [7:0] lit;
    op  = ins[14:12];
    dst = ins[11:10];
    src = ins[9:8];
    lit = ins[7:0];
    if (dst == 2'b11) model = {src, op, 1'b0, 1'b0, 1'b1, 1'b1, lit, cnt};
    else              model = {src, op, dst == 2'b01, dst == 2'b10, 1'b0, 1'b0, 8'h00, cnt};
  endfunction

  task automatic push_exp(input logic [14:0] ins);
    exp_q.push_back(model(ins, exp_cnt));
    exp_cnt = exp_cnt + 1'b1;
  endtask

  // Monitor: compare every retirement against the head of the queue.
  always @(negedge clk_i) begin
    if (rst_ni && pc_inc_o) begin
      check("retire_q_nonempty", exp_q.size() != 0, 1'b1);
      if (exp_q.size() != 0)
        check("retire", {sel_b_o, alu_op_o, reg_a_we_o, reg_b_we_o, mem_req_o, mem_we_o,
                         mem_addr_o, retire_cnt_o}, exp_q.pop_front());
    end
  end

  // Driver tasks (inputs change 1 time unit after the rising edge)
  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic wait_fetch(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 32; i++) begin
      if (fetch_req_o) begin
        ok = 1'b1;
        break;
      end
      step();
    end
    check("fetch_wait", ok, 1'b1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_fetch"},  fetch_req_o, 1'b0);
    check({tag, "_sel_b"},  sel_b_o, 2'b11);
    check({tag, "_alu"},    alu_op_o, 3'b000);
    check({tag, "_we"},     {reg_a_we_o, reg_b_we_o}, 2'b00);
    check({tag, "_mem"},    {mem_req_o, mem_we_o, mem_addr_o}, 10'h000);
    check({tag, "_pc_inc"}, pc_inc_o, 1'b0);
    check({tag, "_busy"},   busy_o, 1'b0);
    check({tag, "_cnt"},    retire_cnt_o, 0);
    check({tag, "_err"},    err_o, 1'b0);
  endtask

  // One memory phase of n cycles, acknowledged on the n-th; stray
  // instr_valid_i pulses are thrown in to confirm they are ignored.
  task automatic mem_phase(input int n, input bit we, input logic [7:0] lit,
                           input logic [1:0] src, input logic [2:0] op);
    for (int i = 1; i <= n; i++) begin
      check("mem_req", mem_req_o, 1'b1);
      check("mem_we", mem_we_o, we);
      check("mem_addr", mem_addr_o, lit);
      check("mem_sel_b", sel_b_o, we ? src : 2'b01);
      check("mem_alu", alu_op_o, we ? op : 3'b000);
      check("mem_pc_inc_early", pc_inc_o, 1'b0);
      instr_valid_i = 1'($urandom_range(0, 1));
      instr_i       = 15'($urandom);
      if (i == n) mem_ack_i = 1'b1;
      step();
      mem_ack_i     = 1'b0;
      instr_valid_i = 1'b0;
    end
    check("mem_req_drop", mem_req_o, 1'b0);
  endtask

  task automatic exec_instr(input logic [14:0] ins, input int rd_n, input int wr_n,
                            input bit drop_run);
    bit ok;
    logic [2:0] op;
    logic [1:0] dst;
    logic [1:0] src;
    logic [7:0] lit;
    op  = ins[14:12];
    dst = ins[11:10];
    src = ins[9:8];
    lit = ins[7:0];
    wait_fetch(ok);
    if (!ok) return;
    mem_ack_i = 1'b1;
    step();
    mem_ack_i = 1'b0;
    check("ack_in_fetch", fetch_req_o, 1'b1);
    instr_i       = ins;
    instr_valid_i = 1'b1;
    push_exp(ins);
    step();
    instr_valid_i = 1'b0;
    instr_i       = 15'($urandom);
    check("decode_busy", {busy_o, fetch_req_o}, 2'b10);
    step();
    if (src == 2'b01) begin
      if (drop_run) run_i = 1'b0;
      mem_phase(rd_n, 1'b0, lit, src, op);
    end
    check("exec_sel_b", sel_b_o, src);
    check("exec_alu", alu_op_o, op);
    check("exec_we", {reg_a_we_o, reg_b_we_o}, {dst == 2'b01, dst == 2'b10});
    check("exec_pc_inc", pc_inc_o, dst != 2'b11);
    check("exec_mem_req", mem_req_o, 1'b0);
    step();
    if (dst == 2'b11) mem_phase(wr_n, 1'b1, lit, src, op);
  endtask

  // Main stimulus
  initial begin
    bit ok;
    n_cmp         = 0;
    n_err         = 0;
    exp_cnt       = '0;
    rst_ni        = 1'b0;
    run_i         = 1'b0;
    instr_valid_i = 1'b0;
    instr_i       = '0;
    mem_ack_i     = 1'b0;

    #12;
    check_reset_outputs("reset");
    step();
    rst_ni = 1'b1;

    // Minimum latency: FETCH, DECODE, EXEC with valid held from the start.
    run_i         = 1'b1;
    instr_i       = 15'h0400;
    instr_valid_i = 1'b1;
    push_exp(15'h0400);
    step();
    check("lat_c1_fetch", {fetch_req_o, busy_o}, 2'b11);
    step();
    check("lat_c2_decode", {fetch_req_o, busy_o, reg_a_we_o}, 3'b010);
    instr_valid_i = 1'b0;
    run_i         = 1'b0;
    step();
    check("lat_c3_exec", {sel_b_o, reg_a_we_o, reg_b_we_o, pc_inc_o}, 5'b00101);
    step();
    check("lat_c4_idle", {reg_a_we_o, pc_inc_o, busy_o}, 3'b000);
    check("lat_cnt", retire_cnt_o, 1);

    // Directed memory phases and read-modify-write.
    run_i = 1'b1;
    exec_instr(15'h093C, 4, 1, 1'b0);
    exec_instr(15'h1E80, 1, 2, 1'b0);
    exec_instr(15'h5DA5, 2, 3, 1'b0);

    // Random instructions and handshake delays; retire count wraps at 16.
    for (int i = 0; i < 24; i++)
      exec_instr(15'($urandom), $urandom_range(1, 4), $urandom_range(1, 4), 1'b0);

    // run_i dropped in MEM_RD: instruction completes, then IDLE.
    exec_instr(15'h2512, 3, 1, 1'b1);
    check("drop_idle", {busy_o, fetch_req_o}, 2'b00);
    for (int i = 0; i < 4; i++) begin
      instr_valid_i = 1'b1;
      mem_ack_i     = 1'b1;
      step();
      check("drop_hold", {busy_o, fetch_req_o}, 2'b00);
    end
    instr_valid_i = 1'b0;
    mem_ack_i     = 1'b0;
    run_i         = 1'b1;
    exec_instr(15'h3801, 1, 1, 1'b0);
    check("cnt_before_rst", retire_cnt_o, exp_cnt);

    // Asynchronous reset in the middle of a MEM_WR wait.
    wait_fetch(ok);
    instr_i       = 15'h1C07;
    instr_valid_i = 1'b1;
    step();
    instr_valid_i = 1'b0;
    step();
    step();
    check("rst_wr_active", {mem_req_o, mem_we_o, mem_addr_o}, 10'h307);
    #3;
    rst_ni    = 1'b0;
    mem_ack_i = 1'b1;
    #1;
    check_reset_outputs("async_rst");
    exp_q.delete();
    exp_cnt   = '0;
    mem_ack_i = 1'b0;
    step();
    rst_ni = 1'b1;
    exec_instr(15'h4B11, 2, 1, 1'b0);
    exec_instr(15'h6C22, 1, 2, 1'b0);
    check("cnt_after_rst", retire_cnt_o, exp_cnt);

`ifdef OPERAND_SEQ_TIMEOUT_EN
    // MEM_RD never acknowledged: ERROR after 8 waiting cycles.
    wait_fetch(ok);
    instr_i       = 15'h0500;
    instr_valid_i = 1'b1;
    step();
    instr_valid_i = 1'b0;
    step();
    for (int i = 0; i < 8; i++) begin
      check("to_wait", {mem_req_o, err_o}, 2'b10);
      step();
    end
    check("to_err", {err_o, mem_req_o, busy_o, sel_b_o}, 5'b10111);
    for (int i = 0; i < 10; i++) begin
      step();
      check("to_sticky", {err_o, fetch_req_o, mem_req_o}, 3'b100);
    end
    rst_ni = 1'b0;
    #1;
    check("to_rst_err", err_o, 1'b0);
    exp_cnt = '0;
    step();
    rst_ni = 1'b1;
`endif

    run_i = 1'b0;
    repeat (3) step();
    check("end_cnt", retire_cnt_o, exp_cnt);
    check("q_drain", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
